rbuffer_ctrl: RTL and testbench

Sequencing controller for the 5-byte UART receive buffer. It sits between the UART receiver and the buffer. It takes received bytes, writes them into the buffer, detects frame completion and inter-byte timeouts, and confirms pointer alignment through the buffer's full flag (address 5). It then drains each completed frame byte-by-byte to the consumer over a valid/ready handshake.

---
 rtl/rbuffer_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_rbuffer_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rbuffer_ctrl.sv
// rbuffer_ctrl: sequencing controller for the 5-byte UART receive buffer.
// Writes received bytes into the buffer and pads partial frames after an
// idle timeout. It confirms pointer alignment through the buffer full flag
// (address 5), then drains each completed frame over a valid/ready handshake.
// The buffer pointer itself is never reset, so the controller re-aligns it
// with PAD_BYTE writes whenever it leaves reset or a full-flag check fails.
module rbuffer_ctrl #(
    parameter int         FRAME_LEN      = 5,      // tied to the buffer depth
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [7:0] PAD_BYTE       = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       buf_wr,
    output logic [7:0] buf_wdata,
    output logic [2:0] buf_addr,
    input  logic [7:0] buf_rdata,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       resync,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    localparam logic [2:0] FLAG_ADDR = 3'd5;
    localparam logic [2:0] SLOT_FULL = 3'(FRAME_LEN);
    localparam logic [2:0] SLOT_LAST = 3'(FRAME_LEN - 1);
    localparam int         TIMER_W   = $clog2(TIMEOUT_CYCLES + 1);
    // The timer holds TIMEOUT_CYCLES-1 in the last idle cycle before padding,
    // so PAD is entered TIMEOUT_CYCLES+1 cycles after the last byte strobe.
    localparam logic [TIMER_W-1:0] TIMER_END  = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};
    localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

    typedef enum logic [2:0] {
        ST_FLUSH_WR  = 3'd0,
        ST_FLUSH_CHK = 3'd1,
        ST_FILL      = 3'd2,
        ST_CHECK     = 3'd3,
        ST_PAD       = 3'd4,
        ST_DRAIN     = 3'd5
    } state_t;

    state_t             state_r,     state_s;
    logic [2:0]         slot_r,      slot_s;
    logic [TIMER_W-1:0] timer_r,     timer_s;
    logic               buf_wr_r,    buf_wr_s;
    logic [7:0]         buf_wdata_r, buf_wdata_s;
    logic [2:0]         buf_addr_r,  buf_addr_s;
    logic               out_valid_r, out_valid_s;
    logic               out_last_r,  out_last_s;
    logic               frame_err_r, frame_err_s;
    logic               resync_r,    resync_s;
    logic [7:0]         drop_cnt_r,  drop_cnt_s;
    logic               busy_r;
    logic               accept_s;

    // A byte is only taken in FILL while the frame still has room; the cycle
    // at slot==FRAME_LEN waits for the last write to land and takes nothing.
    assign accept_s = (state_r == ST_FILL) && (slot_r != SLOT_FULL);

    // Saturating count of received bytes that could not be accepted.
    always_comb begin
        if (rx_valid && !accept_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_s = drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_s = drop_cnt_r;
        end
    end

    // Next-state logic and next values of every registered output.
    always_comb begin
        state_s     = state_r;
        slot_s      = slot_r;
        timer_s     = timer_r;
        buf_wr_s    = 1'b0;
        buf_wdata_s = buf_wdata_r;
        buf_addr_s  = buf_addr_r;
        out_valid_s = out_valid_r;
        out_last_s  = out_last_r;
        frame_err_s = frame_err_r;
        resync_s    = 1'b0;

        case (state_r)
            ST_FLUSH_WR: begin
                // Entry from a failed check already launched the write; the
                // first cycle after reset has to launch it here.
                if (buf_wr_r) begin
                    state_s    = ST_FLUSH_CHK;
                    buf_addr_s = FLAG_ADDR;
                end else begin
                    buf_wr_s    = 1'b1;
                    buf_wdata_s = PAD_BYTE;
                end
            end

            ST_FLUSH_CHK: begin
                if (buf_rdata[0]) begin
                    state_s    = ST_FILL;
                    slot_s     = 3'd0;
                    timer_s    = TIMER_ZERO;
                    buf_addr_s = 3'd0;
                end else begin
                    state_s     = ST_FLUSH_WR;
                    buf_wr_s    = 1'b1;
                    buf_wdata_s = PAD_BYTE;
                end
            end

            ST_FILL: begin
                if (slot_r == SLOT_FULL) begin
                    state_s    = ST_CHECK;
                    buf_addr_s = FLAG_ADDR;
                    timer_s    = TIMER_ZERO;
                end else if (rx_valid) begin
                    // A byte arriving on the expiry cycle still wins.
                    buf_wr_s    = 1'b1;
                    buf_wdata_s = rx_data;
                    slot_s      = slot_r + 3'd1;
                    timer_s     = TIMER_ZERO;
                end else if (slot_r != 3'd0) begin
                    if (timer_r == TIMER_END) begin
                        state_s     = ST_PAD;
                        frame_err_s = 1'b1;
                        timer_s     = TIMER_ZERO;
                        buf_wr_s    = 1'b1;
                        buf_wdata_s = PAD_BYTE;
                        slot_s      = slot_r + 3'd1;
                    end else begin
                        timer_s = timer_r + TIMER_ONE;
                    end
                end else begin
                    timer_s = TIMER_ZERO;
                end
            end

            ST_PAD: begin
                if (slot_r == SLOT_FULL) begin
                    state_s    = ST_CHECK;
                    buf_addr_s = FLAG_ADDR;
                end else begin
                    buf_wr_s    = 1'b1;
                    buf_wdata_s = PAD_BYTE;
                    slot_s      = slot_r + 3'd1;
                end
            end

            ST_CHECK: begin
                if (buf_rdata[0]) begin
                    state_s     = ST_DRAIN;
                    slot_s      = 3'd0;
                    buf_addr_s  = 3'd0;
                    out_valid_s = 1'b1;
                    out_last_s  = (SLOT_LAST == 3'd0);
                end else begin
                    // Pointer out of step: drop the frame and re-align.
                    state_s     = ST_FLUSH_WR;
                    resync_s    = 1'b1;
                    frame_err_s = 1'b0;
                    slot_s      = 3'd0;
                    buf_wr_s    = 1'b1;
                    buf_wdata_s = PAD_BYTE;
                end
            end

            ST_DRAIN: begin
                if (out_valid_r && out_ready) begin
                    if (slot_r == SLOT_LAST) begin
                        state_s     = ST_FILL;
                        slot_s      = 3'd0;
                        timer_s     = TIMER_ZERO;
                        buf_addr_s  = 3'd0;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        frame_err_s = 1'b0;
                    end else begin
                        slot_s     = slot_r + 3'd1;
                        buf_addr_s = slot_r + 3'd1;
                        out_last_s = ((slot_r + 3'd1) == SLOT_LAST);
                    end
                end else begin
                    slot_s = slot_r;
                end
            end

            default: begin
                state_s     = ST_FLUSH_WR;
                slot_s      = 3'd0;
                timer_s     = TIMER_ZERO;
                out_valid_s = 1'b0;
                out_last_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_FLUSH_WR;
            slot_r      <= 3'd0;
            timer_r     <= TIMER_ZERO;
            buf_wr_r    <= 1'b0;
            buf_wdata_r <= 8'h00;
            buf_addr_r  <= 3'd0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            frame_err_r <= 1'b0;
            resync_r    <= 1'b0;
            drop_cnt_r  <= 8'h00;
            busy_r      <= 1'b1;
        end else begin
            state_r     <= state_s;
            slot_r      <= slot_s;
            timer_r     <= timer_s;
            buf_wr_r    <= buf_wr_s;
            buf_wdata_r <= buf_wdata_s;
            buf_addr_r  <= buf_addr_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
            frame_err_r <= frame_err_s;
            resync_r    <= resync_s;
            drop_cnt_r  <= drop_cnt_s;
            busy_r      <= (state_s != ST_FILL);
        end
    end

    assign buf_wr    = buf_wr_r;
    assign buf_wdata = buf_wdata_r;
    assign buf_addr  = buf_addr_r;
    assign out_valid = out_valid_r;
    // The buffer read port is combinational and buf_addr is held during a
    // stall, so the frame byte is taken straight from it.
    assign out_data  = buf_rdata;
    assign out_last  = out_last_r;
    assign frame_err = frame_err_r;
    assign resync    = resync_r;
    assign drop_cnt  = drop_cnt_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rbuffer_ctrl.sv
// Testbench for rbuffer_ctrl: buffer model, frame-level reference model,
// scoreboard queue of expected drained bytes and an independent monitor.
module tb_rbuffer_ctrl;

    localparam int         TO       = 40;
    localparam logic [7:0] PAD      = 8'h00;
    localparam int         PTR_INIT = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic       out_ready = 1'b0;
    logic       buf_wr;
    logic [7:0] buf_wdata;
    logic [2:0] buf_addr;
    logic [7:0] buf_rdata;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       frame_err;
    logic       resync;
    logic [7:0] drop_cnt;
    logic       busy;

    always #5 clk = ~clk;

    rbuffer_ctrl #(.FRAME_LEN(5), .TIMEOUT_CYCLES(TO), .PAD_BYTE(PAD)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .buf_wr(buf_wr), .buf_wdata(buf_wdata), .buf_addr(buf_addr),
        .buf_rdata(buf_rdata), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .frame_err(frame_err),
        .resync(resync), .drop_cnt(drop_cnt), .busy(busy)
    );

    // ---------------- buffer model: 5 bytes, free-running write pointer ----
    logic [7:0] mem [5] = '{default: 8'h00};
    int         ptr       = PTR_INIT;
    int         wr_count  = 0;
    logic       force_bad = 1'b0;

    always @(posedge clk) begin
        if (buf_wr) begin
            mem[ptr] <= buf_wdata;
            ptr      <= (ptr + 1) % 5;
            wr_count <= wr_count + 1;
        end
    end

    always_comb begin
        if (buf_addr < 3'd5) buf_rdata = mem[buf_addr];
        else                 buf_rdata = {7'd0, (ptr == 0) && !force_bad};
    end

    // ---------------- reference model and scoreboard ----------------------
    typedef struct packed { logic [7:0] d; logic l; logic e; } exp_t;
    exp_t       exp_q [$];
    logic [7:0] cur [$];
    logic       cur_err = 1'b0;
    int         drops   = 0;
    int         tests   = 0;
    int         fails   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic commit();
        for (int i = 0; i < 5; i++) exp_q.push_back('{d: cur[i], l: (i == 4), e: cur_err});
        cur.delete();
        cur_err = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] b);
        cur.push_back(b);
        if (cur.size() == 5) commit();
    endtask

    task automatic model_drop();
        if (drops < 255) drops++;
    endtask

    task automatic model_timeout();
        cur_err = 1'b1;
        while (cur.size() < 5) cur.push_back(PAD);
        commit();
    endtask

    // ---------------- monitor ---------------------------------------------
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_data);
                check("hold_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_output: got %0h expected none", out_data);
                end else begin
                    tests--;
                    check("out_data", out_data, exp_q[0].d);
                    check("out_last", out_last, exp_q[0].l);
                    check("frame_err", frame_err, exp_q[0].e);
                    void'(exp_q.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_last  <= out_last;
        end
    end

    // ---------------- stimulus helpers ------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic wait_flush(input string name, input int wr0, input int exp_writes);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 40);
        check({name, "_done"}, busy, 0);
        check({name, "_writes"}, wr_count - wr0, exp_writes);
        tick();
    endtask

    // mode 1: always ready, mode 2: random ready
    task automatic drain(input string name, input int mode);
        int  n    = 0;
        bit  done = 0;
        while (!done && n < 300) begin
            out_ready = (mode == 1) ? 1'b1 : 1'($urandom % 2);
            @(negedge clk);
            if (out_valid && out_ready && out_last) done = 1;
            n++;
            tick();
        end
        out_ready = 1'b0;
        check({name, "_drained"}, done, 1);
        @(negedge clk);
        check({name, "_idle"}, busy, 0);
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        check({name, "_valid"}, out_valid, 1);
        tick();
    endtask

    // ---------------- main sequence ---------------------------------------
    initial begin
        int         n;
        int         cnt;
        int         wr0;
        int         pads;
        bit         saw_valid;
        logic [7:0] b;
        logic [7:0] clean [5];
        clean = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        // reset values
        @(negedge clk);
        @(negedge clk);
        check("rst_buf_wr", buf_wr, 0);
        check("rst_buf_wdata", buf_wdata, 0);
        check("rst_buf_addr", buf_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_resync", resync, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        tick();
        rst_n = 1'b1;

        // initial flush realigns the pointer that starts at PTR_INIT
        wait_flush("init_flush", wr_count, 5 - PTR_INIT);

        // clean frame with latency and length checks
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive_byte(clean[i]);
            model_accept(clean[i]);
        end
        n = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 10);
        check("clean_latency", n, 3);
        cnt = 0;
        while (out_valid && cnt < 10) begin cnt++; @(negedge clk); end
        check("clean_len", cnt, 5);
        tick();
        out_ready = 1'b0;

        // timeout: two bytes then silence
        drive_byte(8'hAA); model_accept(8'hAA);
        drive_byte(8'hBB); model_accept(8'hBB);
        n = 0;
        do begin @(negedge clk); n++; end while (!(buf_wr && n > 1) && n < TO + 20);
        check("timeout_pad_cycle", n, TO + 1);
        pads = 0;
        repeat (4) begin
            if (buf_wr) begin
                pads++;
                check("pad_value", buf_wdata, PAD);
            end
            @(negedge clk);
        end
        check("pad_count", pads, 3);
        tick();
        model_timeout();
        drain("timeout", 1);

        // backpressure with a dropped byte during the stall
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(255, 0));
            drive_byte(b);
            model_accept(b);
        end
        wait_valid("bp");
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin rx_data = 8'h77; rx_valid = 1'b1; end
            @(negedge clk);
            if (exp_q.size() > 0) check("bp_hold_byte0", out_data, exp_q[0].d);
            else check("bp_queue", exp_q.size(), 5);
            tick();
            if (i == 3) begin rx_valid = 1'b0; model_drop(); end
        end
        @(negedge clk);
        check("bp_drop_cnt", drop_cnt, drops);
        tick();
        drain("bp", 2);

        // randomized frames with inter-byte gaps and random backpressure
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 5; i++) begin
                b = 8'($urandom_range(255, 0));
                drive_byte(b);
                model_accept(b);
                repeat ($urandom_range(3, 0)) tick();
            end
            drain("rand", 2);
        end

        // resync: full flag reads 0 at CHECK, frame discarded
        force_bad = 1'b1;
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom_range(255, 0)));
        n = 0;
        saw_valid = 0;
        do begin
            @(negedge clk); n++;
            if (out_valid) saw_valid = 1;
        end while (!resync && n < 10);
        check("resync_cycle", n, 3);
        force_bad = 1'b0;
        wr0 = wr_count;
        @(negedge clk);
        check("resync_width", resync, 0);
        if (out_valid) saw_valid = 1;
        tick();
        wait_flush("resync_flush", wr0, 5);
        check("resync_no_valid", saw_valid, 0);
        check("resync_err_clear", frame_err, 0);

        // reset in the middle of a fill
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom_range(255, 0)));
        tick(); tick();
        wr0 = wr_count;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drops = 0;
        cur.delete();
        cur_err = 1'b0;
        @(negedge clk);
        check("midrst_drop_cnt", drop_cnt, drops);
        tick();
        wait_flush("midrst_flush", wr0, 5 - 3);
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(255, 0));
            drive_byte(b);
            model_accept(b);
        end
        drain("midrst", 1);

        // drop counter saturation during a stalled drain
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(255, 0));
            drive_byte(b);
            model_accept(b);
        end
        wait_valid("sat");
        for (int i = 0; i < 300; i++) begin
            drive_byte(8'($urandom_range(255, 0)));
            model_drop();
        end
        @(negedge clk);
        check("sat_drop_cnt", drop_cnt, drops);
        tick(); tick(); tick();
        @(negedge clk);
        check("sat_hold", drop_cnt, 255);
        tick();
        drain("sat", 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
